// File: rtl/atomic_mem_unit.sv
// Atomic memory unit for RV32A.
// Runs the read-modify-write sequence of an AMO, LR or SC on a single data-memory port.
// It also holds the one LR/SC reservation.
// The pipeline stalls while busy is high.
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   start              request strobe, accepted only while idle
//   alu_control        ALU_* op code, sampled with start
//   addr, rs2_data     rs1 address and operand/store data, sampled with start
//   resv_clear         external write hit the reserved word; kills the reservation
//   busy, done         busy from the cycle after accept through the done cycle; done is a pulse
//   rd_data            old memory value (AMO/LR); 0 = SC success, 1 = SC fail
//   mem_req, mem_we    memory request (held until mem_ready) and write enable
//   mem_addr           word-aligned address
//   mem_wdata          write data
//   mem_rdata          read data
//   mem_ready          completes the current request in the same cycle
module atomic_mem_unit #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        alu_control,
  input  logic [ADDR_W-1:0] addr,
  input  logic [XLEN-1:0]   rs2_data,
  input  logic              resv_clear,
  output logic              busy,
  output logic              done,
  output logic [XLEN-1:0]   rd_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_ready
);

  localparam logic [3:0] ALU_SWAP = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_MIN  = 4'd5;
  localparam logic [3:0] ALU_MAX  = 4'd6;
  localparam logic [3:0] ALU_LR   = 4'd7;
  localparam logic [3:0] ALU_SC   = 4'd8;

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e            state_q;
  logic [3:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   rs2_q;
  logic              resv_valid;
  logic [ADDR_W-1:0] resv_addr;

  logic [ADDR_W-1:0] word_addr;
  logic [XLEN-1:0]   amo_sum;
  logic [XLEN-1:0]   amo_result;
  logic              unused_addr_lsb;

  assign word_addr       = {addr[ADDR_W-1:2], 2'b00};
  assign unused_addr_lsb = ^addr[1:0];
  assign amo_sum         = mem_rdata + rs2_q;

  // New memory value, computed from the read data in the cycle the read completes.
  always_comb begin
    amo_result = amo_sum;
    case (op_q)
      ALU_SWAP: amo_result = rs2_q;
      ALU_ADD:  amo_result = amo_sum;
      ALU_AND:  amo_result = mem_rdata & rs2_q;
      ALU_OR:   amo_result = mem_rdata | rs2_q;
      ALU_XOR:  amo_result = mem_rdata ^ rs2_q;
      ALU_MIN:  amo_result = ($signed(mem_rdata) < $signed(rs2_q)) ? mem_rdata : rs2_q;
      ALU_MAX:  amo_result = ($signed(mem_rdata) > $signed(rs2_q)) ? mem_rdata : rs2_q;
      default:  amo_result = amo_sum;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      op_q       <= 4'd0;
      addr_q     <= '0;
      rs2_q      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      rd_data    <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      resv_valid <= 1'b0;
      resv_addr  <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            op_q     <= alu_control;
            addr_q   <= word_addr;
            rs2_q    <= rs2_data;
            mem_addr <= word_addr;
            busy     <= 1'b1;
            if (alu_control == ALU_SC) begin
              resv_valid <= 1'b0;
              if (resv_valid && (resv_addr == word_addr)) begin
                state_q   <= StWrite;
                mem_req   <= 1'b1;
                mem_we    <= 1'b1;
                mem_wdata <= rs2_data;
              end else begin
                // Failed SC never touches memory.
                state_q <= StDone;
                done    <= 1'b1;
                rd_data <= XLEN'(1);
              end
            end else begin
              state_q <= StRead;
              mem_req <= 1'b1;
              mem_we  <= 1'b0;
            end
          end
        end
        StRead: begin
          if (mem_ready) begin
            rd_data <= mem_rdata;
            if (op_q == ALU_LR) begin
              state_q    <= StDone;
              mem_req    <= 1'b0;
              done       <= 1'b1;
              resv_valid <= 1'b1;
              resv_addr  <= addr_q;
            end else begin
              state_q   <= StWrite;
              mem_we    <= 1'b1;
              mem_wdata <= amo_result;
            end
          end
        end
        StWrite: begin
          if (mem_ready) begin
            state_q <= StDone;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            done    <= 1'b1;
            if (op_q == ALU_SC) begin
              rd_data <= '0;
            end else if (resv_addr == addr_q) begin
              resv_valid <= 1'b0;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
      // Last assignment so an external clear beats an LR completing in the same cycle.
      if (resv_clear) resv_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_atomic_mem_unit.sv
// Self-checking bench for atomic_mem_unit.
// It uses a memory responder with configurable wait states, a table of directed vectors,
// hand-written corner sequences, and a random phase checked against a reference model.
module tb_atomic_mem_unit;

  localparam logic [3:0] ALU_SWAP = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_MIN  = 4'd5;
  localparam logic [3:0] ALU_MAX  = 4'd6;
  localparam logic [3:0] ALU_LR   = 4'd7;
  localparam logic [3:0] ALU_SC   = 4'd8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  alu_control = 4'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] rs2_data = 32'd0;
  logic        resv_clear = 1'b0;
  logic        busy, done, mem_req, mem_we, mem_ready;
  logic [31:0] rd_data, mem_addr, mem_wdata, mem_rdata;

  atomic_mem_unit #(.XLEN(32), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .alu_control(alu_control), .addr(addr),
    .rs2_data(rs2_data), .resv_clear(resv_clear), .busy(busy), .done(done),
    .rd_data(rd_data), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  // Memory responder: wait_cfg not-ready cycles per request, then ready.
  logic [31:0] mem [0:255];
  int          wait_cfg = 0;
  int          wcnt = 0;
  int          wr_count = 0;
  logic        pl_en = 1'b0;
  logic [7:0]  pl_idx = 8'd0;
  logic [31:0] pl_data = 32'd0;

  assign mem_ready = mem_req && (wcnt >= wait_cfg);
  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    if (mem_req) begin
      if (wcnt < wait_cfg) wcnt <= wcnt + 1;
      else begin
        wcnt <= 0;
        if (mem_we) begin
          mem[mem_addr[9:2]] <= mem_wdata;
          wr_count <= wr_count + 1;
        end
      end
    end else wcnt <= 0;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic poke(input logic [31:0] a, input logic [31:0] d);
    pl_idx = a[9:2]; pl_data = d; pl_en = 1'b1;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic pulse_clear();
    resv_clear = 1'b1;
    @(posedge clk); #1;
    resv_clear = 1'b0;
  endtask

  // Called at #1 after an edge with the DUT idle. Returns rd, latency in edges, writes seen.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] rs2,
                        input int w, input bit noise, input bit stable_chk,
                        output logic [31:0] rd, output int lat, output int nwr);
    int wr0 = wr_count;
    int c = 0;
    wait_cfg = w;
    alu_control = op; addr = a; rs2_data = rs2; start = 1'b1;
    @(posedge clk); #1;
    if (!noise) start = 1'b0;
    chk("busy_after_start", busy, 1);
    while (!done && c < 80) begin
      if (mem_req) chk("mem_addr", mem_addr, a & ~32'h3);
      if (stable_chk) begin
        chk("stall_req", mem_req, 1);
        chk("stall_we", mem_we, c >= w + 1);
      end
      if (noise) begin
        start = 1'b1; alu_control = 4'($urandom_range(0, 15));
        addr = $urandom; rs2_data = $urandom;
      end
      @(posedge clk); #1;
      c++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL done_timeout actual=%0d expected=done", c);
    end
    lat = c + 1;
    rd = rd_data;
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_pulse", done, 0);
    chk("busy_clear", busy, 0);
    nwr = wr_count - wr0;
  endtask

  function automatic logic [31:0] amo_fn(input logic [3:0] op, input logic [31:0] o,
                                         input logic [31:0] b);
    case (op)
      ALU_SWAP: return b;
      ALU_AND:  return o & b;
      ALU_OR:   return o | b;
      ALU_XOR:  return o ^ b;
      ALU_MIN:  return ($signed(o) < $signed(b)) ? o : b;
      ALU_MAX:  return ($signed(o) > $signed(b)) ? o : b;
      default:  return o + b;
    endcase
  endfunction

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] rs2;
    bit          pl;
    logic [31:0] pl_data;
    logic [31:0] exp_rd;
    logic [31:0] exp_mem;
    int          exp_lat;
    int          exp_wr;
  } vec_t;

  vec_t        vecs [11];
  logic [31:0] rd, ref_mem [0:255], old, e_rd;
  int          lat, nwr, e_lat, e_wr, r, w, ref_ra;
  bit          ref_rv, nz;
  logic [3:0]  op;
  logic [31:0] a, rs2;
  logic [7:0]  idx;

  initial begin
    vecs[0]  = '{ALU_ADD,  32'h40, 32'h3,        1, 32'h5,        32'h5,        32'h8,        3, 1};
    vecs[1]  = '{ALU_MIN,  32'h10, 32'h1,        1, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFE, 3, 1};
    vecs[2]  = '{ALU_MAX,  32'h10, 32'h1,        0, 32'h0,        32'hFFFFFFFE, 32'h1,        3, 1};
    vecs[3]  = '{ALU_LR,   32'h80, 32'h0,        1, 32'h7,        32'h7,        32'h7,        2, 0};
    vecs[4]  = '{ALU_SC,   32'h80, 32'h9,        0, 32'h0,        32'h0,        32'h9,        2, 1};
    vecs[5]  = '{ALU_SC,   32'h80, 32'h5,        0, 32'h0,        32'h1,        32'h9,        1, 0};
    vecs[6]  = '{ALU_XOR,  32'h44, 32'hF0F0,     1, 32'h0FF0,     32'h0FF0,     32'hFF00,     3, 1};
    vecs[7]  = '{ALU_SWAP, 32'h4B, 32'hDEADBEEF, 1, 32'h1234,     32'h1234,     32'hDEADBEEF, 3, 1};
    vecs[8]  = '{4'hF,     32'h4C, 32'h10,       1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0000000F, 3, 1};
    vecs[9]  = '{ALU_AND,  32'h50, 32'hFF00,     1, 32'hF0F0,     32'hF0F0,     32'hF000,     3, 1};
    vecs[10] = '{ALU_OR,   32'h55, 32'hF0,       1, 32'h0F,       32'h0F,       32'hFF,       3, 1};

    // Reset values.
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_busy", busy, 0);   chk("rst_done", done, 0);     chk("rst_rd", rd_data, 0);
    chk("rst_req", mem_req, 0); chk("rst_we", mem_we, 0);     chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);

    // Directed table.
    foreach (vecs[i]) begin
      if (vecs[i].pl) poke(vecs[i].addr, vecs[i].pl_data);
      run_op(vecs[i].op, vecs[i].addr, vecs[i].rs2, 0, 0, 0, rd, lat, nwr);
      chk($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
      chk($sformatf("vec%0d_wr", i), nwr, vecs[i].exp_wr);
      chk($sformatf("vec%0d_mem", i), mem[vecs[i].addr[9:2]], vecs[i].exp_mem);
    end

    // LR, external clear, then SC fails without touching memory.
    run_op(ALU_LR, 32'h80, 0, 0, 0, 0, rd, lat, nwr);
    chk("lr_clear_rd", rd, 32'h9);
    pulse_clear();
    run_op(ALU_SC, 32'h80, 32'h77, 0, 0, 0, rd, lat, nwr);
    chk("sc_cleared_rd", rd, 1); chk("sc_cleared_wr", nwr, 0); chk("sc_cleared_lat", lat, 1);
    chk("sc_cleared_mem", mem[8'h20], 32'h9);

    // SC to a different word than the reservation.
    run_op(ALU_LR, 32'h80, 0, 0, 0, 0, rd, lat, nwr);
    run_op(ALU_SC, 32'h84, 32'h77, 0, 0, 0, rd, lat, nwr);
    chk("sc_other_rd", rd, 1); chk("sc_other_wr", nwr, 0);

    // Clear arriving in the same cycle the LR completes wins.
    wait_cfg = 0;
    alu_control = ALU_LR; addr = 32'h60; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; resv_clear = 1'b1;
    @(posedge clk); #1;
    resv_clear = 1'b0;
    chk("lr_race_done", done, 1);
    @(posedge clk); #1;
    run_op(ALU_SC, 32'h60, 32'h5, 0, 0, 0, rd, lat, nwr);
    chk("lr_race_sc_rd", rd, 1); chk("lr_race_sc_wr", nwr, 0);

    // Wait states with start noise while busy.
    poke(32'h70, 32'd100);
    run_op(ALU_ADD, 32'h70, 32'd23, 4, 1, 1, rd, lat, nwr);
    chk("wait_rd", rd, 32'd100); chk("wait_lat", lat, 11); chk("wait_wr", nwr, 1);
    chk("wait_mem", mem[8'h1C], 32'd123);

    // Reset during the WRITE of a SWAP.
    poke(32'h30, 32'h55);
    poke(32'h20, 32'hAAAA);
    run_op(ALU_LR, 32'h30, 0, 0, 0, 0, rd, lat, nwr);
    chk("pre_rst_lr_rd", rd, 32'h55);
    wait_cfg = 3;
    alu_control = ALU_SWAP; addr = 32'h20; rs2_data = 32'h1111; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 20 && !mem_we; k++) begin
      @(posedge clk); #1;
    end
    chk("swap_in_write", mem_we, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid_rst_req", mem_req, 0);   chk("mid_rst_busy", busy, 0);
    chk("mid_rst_we", mem_we, 0);     chk("mid_rst_rd", rd_data, 0);
    chk("mid_rst_wdata", mem_wdata, 0); chk("mid_rst_addr", mem_addr, 0);
    chk("mid_rst_mem", mem[8'h08], 32'hAAAA);
    run_op(ALU_SC, 32'h30, 32'h99, 0, 0, 0, rd, lat, nwr);
    chk("post_rst_sc_rd", rd, 1); chk("post_rst_sc_wr", nwr, 0);

    // Random phase against the reference model.
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    ref_rv = 0; ref_ra = 0;
    for (int i = 0; i < 4; i++) begin
      ref_mem[i] = $urandom;
      poke(32'(i * 4), ref_mem[i]);
    end
    for (int i = 0; i < 150; i++) begin
      r   = $urandom_range(0, 19);
      op  = (r < 16) ? 4'(r) : ((r < 18) ? ALU_LR : ALU_SC);
      a   = 32'(($urandom_range(0, 3) << 2) | $urandom_range(0, 3));
      rs2 = $urandom;
      w   = $urandom_range(0, 2);
      nz  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) begin
        pulse_clear();
        ref_rv = 0;
      end
      idx = a[9:2];
      old = ref_mem[idx];
      if (op == ALU_SC) begin
        if (ref_rv && ref_ra == int'(idx)) begin
          e_rd = 0; e_lat = 2 + w; e_wr = 1; ref_mem[idx] = rs2;
        end else begin
          e_rd = 1; e_lat = 1; e_wr = 0;
        end
        ref_rv = 0;
      end else if (op == ALU_LR) begin
        e_rd = old; e_lat = 2 + w; e_wr = 0;
        ref_rv = 1; ref_ra = int'(idx);
      end else begin
        e_rd = old; e_lat = 3 + 2 * w; e_wr = 1;
        ref_mem[idx] = amo_fn(op, old, rs2);
        if (ref_rv && ref_ra == int'(idx)) ref_rv = 0;
      end
      run_op(op, a, rs2, w, nz, 0, rd, lat, nwr);
      chk($sformatf("rnd%0d_rd", i), rd, e_rd);
      chk($sformatf("rnd%0d_lat", i), lat, e_lat);
      chk($sformatf("rnd%0d_wr", i), nwr, e_wr);
      chk($sformatf("rnd%0d_mem", i), mem[idx], ref_mem[idx]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
